// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int ITER_CNT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 iteration on the {upper, lower} accumulator: shift-add multiply,
// plus a restoring-divide step when MULDIV_DIV_EN is defined.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = ITER_CNT
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
`ifdef MULDIV_DIV_EN
  input  logic               is_div,
`endif
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Remainder shifted left with the next dividend bit pulled in from the lower half.
  assign rem_sh = acc[2*WIDTH-1:WIDTH-1];
  assign diff   = rem_sh - {1'b0, opnd};

  always_comb begin
    acc_nxt = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (diff[WIDTH]) acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end
`else
  assign acc_nxt = {sum, acc[WIDTH-1:1]};
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: FSM, operand magnitudes, sign fix and HI/LO.
// MULDIV_DIV_EN enables DIV/DIVU; without it only MULT/MULTU are accepted.
//
// state | meaning
// IDLE  | HI/LO writable, waiting for an accepted start
// RUN   | one iteration per cycle, counter 0..WIDTH-1
// FIX   | sign correction, commit HI/LO on the closing edge
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = ITER_CNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state;
  logic [CW-1:0]      cnt;
  logic               div_q;
  logic               neg_res;
  logic               neg_rem;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               div_in, sgn_in, a_neg, b_neg, op_ok, dz, accept;

  assign div_in = (op == OP_DIV) || (op == OP_DIVU);
  assign sgn_in = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg  = sgn_in & a[WIDTH-1];
  assign b_neg  = sgn_in & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

`ifdef MULDIV_DIV_EN
  assign op_ok = 1'b1;
  assign dz    = div_in & (b == '0);
`else
  assign op_ok = ~div_in;
  assign dz    = 1'b0;
`endif

  assign accept = start & ~done & ~flush & (state == IDLE) & op_ok;
  assign stall  = ~rst & (busy | accept);

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .acc     (acc),
    .opnd    (opnd),
`ifdef MULDIV_DIV_EN
    .is_div  (div_q),
`endif
    .acc_nxt (acc_nxt)
  );

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (div_q) begin
      fix_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (accept) begin
            busy    <= 1'b1;
            cnt     <= '0;
            div_q   <= div_in;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= div_in & a_neg;
            if (dz) begin
              // Divide by zero skips iteration; FIX commits the raw values.
              state   <= FIX;
              acc     <= {a, {WIDTH{1'b1}}};
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
            end else begin
              state <= RUN;
              if (div_in) begin
                acc  <= {{WIDTH{1'b0}}, a_mag};
                opnd <= b_mag;
              end else begin
                acc  <= {{WIDTH{1'b0}}, b_mag};
                opnd <= a_mag;
              end
            end
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle sequencer for the HI/LO multiply/divide unit of the MIPS core. It accepts MULT/MULTU/DIV/DIVU issued from EX and runs an iterative radix-2 shift-add multiplier or restoring divider for 32 cycles. It owns the architectural HI/LO registers and stalls the pipeline until the result is committed. MTHI/MTLO writes are also applied here.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  EX holds a mul/div instruction; level, held while stalled
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- flush  in  1  cancel the in-flight operation (exception/branch flush)
- hi_we  in  1  MTHI write
- lo_we  in  1  MTLO write
- wdata  in  WIDTH  MTHI/MTLO data
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  operation in flight (registered)
- done  out  1  one-cycle pulse, the cycle after HI/LO commit (registered)
- stall  out  1  pipeline hold request (combinational)

## Operation
- States: IDLE, RUN, FIX.
- IDLE → RUN on start & ~done & ~flush. Latches the op, and the magnitudes |a| and |b| for signed ops (raw operands for unsigned). Latches the sign flags. Clears counter.
- Divide by zero: IDLE → FIX directly, with LO=0xFFFFFFFF and HI=a (raw).
- RUN: one iteration per cycle, counter 0..WIDTH-1.
  - Multiply is shift-add into a 2×WIDTH accumulator.
  - Divide is restoring: shift remainder, subtract, set quotient bit.
  - At counter WIDTH-1 → FIX.
- FIX: sign correction.
  - Signed multiply: negate the 64-bit product when the signs differ.
  - Signed divide: negate the quotient when the signs differ; the remainder takes the dividend's sign.
  - At the closing edge, commit HI/LO (mul: HI=upper, LO=lower; div: HI=remainder, LO=quotient) → IDLE, and set done for the next cycle.
- Overflow: -2^31 / -1 gives LO=0x80000000, HI=0 (wraps).
- Arithmetic is modulo 2^WIDTH per register.
- flush in RUN/FIX → IDLE at the next edge. HI/LO unchanged, no done. flush in IDLE blocks acceptance.
- hi_we/lo_we: applied only when state is IDLE; ignored while busy. With start and hi_we in the same IDLE cycle, the write lands now and the later result overwrites it.
- stall = busy | (start & IDLE & ~done & ~flush). The done cycle has stall=0, so EX advances, and the still-high start is ignored.
- Reset: state IDLE, hi=0, lo=0, busy=0, done=0, counter=0; stall forced 0 while rst=1. Reset mid-operation abandons it without commit.

## Timing
- Start sampled at edge E0.
  - busy=1 in cycles 1..WIDTH+1.
  - RUN in cycles 1..WIDTH; FIX in cycle WIDTH+1.
  - HI/LO are visible in cycle WIDTH+2 (34 for WIDTH=32); done=1 in that same cycle only.
- Divide by zero: FIX in cycle 1, done in cycle 2.
- Back-to-back: a new start is accepted in the cycle after done at the earliest.
- One operation in flight max; there is no queueing.

## Configuration
- MULDIV_DIV_EN defined: divider datapath and DIV/DIVU supported as above.
- Undefined: divider logic is omitted. DIV/DIVU starts are not accepted: no stall, no busy, no done, and HI/LO unchanged. Multiply behaviour and timing are identical.

## Structure
- Package muldiv_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - state enum (IDLE/RUN/FIX)
  - iteration count constant
- Sub-module muldiv_iter implements the combinational single-step datapath: shift-add step, and under MULDIV_DIV_EN the restoring-subtract step. It is instanced once.
- muldiv_ctrl keeps the FSM, counter, operand and sign registers, HI/LO, and sign fix.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → HI=0xFFFFFFFE LO=0x00000001; done exactly at cycle 34; stall high cycles 0..33.
- MULT a=0xFFFFFFFD(-3) b=5 → HI=0xFFFFFFFF LO=0xFFFFFFF1; DIVU 7/2 → LO=3 HI=1.
- DIV a=0xFFFFFFF9(-7) b=2 → LO=0xFFFFFFFD HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000 HI=0.
- DIV a=0x1234 b=0 → done at cycle 2, LO=0xFFFFFFFF HI=0x00001234; without MULDIV_DIV_EN → no stall, no done.
- Prior HI=0xA LO=0xB; MULT issued and flush at cycle 10 → busy=0 at cycle 11, no done, HI/LO stay 0xA/0xB; rst at cycle 5 of another op → all outputs 0.
- start held through the done cycle → one operation only; hi_we=1 wdata=0x55 with busy=1 → ignored; same write in IDLE → HI=0x55 next cycle.
